// File: rtl/fluxo_dados_genius_param.sv
// Parametrised datapath for the memory-sequence game (Genius).
// Holds the address/limit counters, a writable sequence RAM, the move and
// memory-data registers, a press edge detector, a display timer and a
// saturating idle timeout.
// Ports:
//   clock, reset_n (async, active-low)
//   botoes            raw (synchronised) button inputs
//   zeraE/L/R/M/TMR   sync clears; contaE/L/TMR increments
//   registraR/M       register loads; escreveM RAM write
//   fimE/L/TMR, jogada_feita, jogada_valida, chavesIgualMemoria,
//   enderecoIgualLimite, enderecoMenorOuIgualLimite, timeout, db_*
// Optional macro GERA_ALEATORIO_EN: RAM write data comes from a 16-bit
// LFSR as a one-hot move instead of the move register.
module fluxo_dados_genius_param #(
    parameter int BTN_W       = 4,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 5000,
    parameter int SHOW_CYC    = 500
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [BTN_W-1:0]  botoes,
    input  logic              zeraE,
    input  logic              zeraL,
    input  logic              zeraR,
    input  logic              zeraM,
    input  logic              zeraTMR,
    input  logic              contaE,
    input  logic              contaL,
    input  logic              contaTMR,
    input  logic              registraR,
    input  logic              registraM,
    input  logic              escreveM,
    output logic              fimE,
    output logic              fimL,
    output logic              fimTMR,
    output logic              jogada_feita,
    output logic              jogada_valida,
    output logic              chavesIgualMemoria,
    output logic              enderecoIgualLimite,
    output logic              enderecoMenorOuIgualLimite,
    output logic              timeout,
    output logic              db_tem_jogada,
    output logic [ADDR_W-1:0] db_contagem,
    output logic [ADDR_W-1:0] db_limite,
    output logic [BTN_W-1:0]  db_jogada,
    output logic [BTN_W-1:0]  db_memoria
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int TMR_W = (SHOW_CYC > 1) ? $clog2(SHOW_CYC) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SHOW_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC);

    logic [ADDR_W-1:0] endereco_q, endereco_d;
    logic [ADDR_W-1:0] limite_q, limite_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [TO_W-1:0]   tout_q, tout_d;
    logic [BTN_W-1:0]  jogada_q, jogada_d;
    logic [BTN_W-1:0]  memoria_q, memoria_d;
    logic              hist_q, hist_d;
    logic [BTN_W-1:0]  rd_q;
    logic [BTN_W-1:0]  wdata;
    logic [BTN_W-1:0]  ram [DEPTH];
    logic              tem;
    logic              tout_hit;

    assign tem      = |botoes;
    assign tout_hit = (tout_q == TO_LAST);

`ifdef GERA_ALEATORIO_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [4:0]  sel;

    // Fibonacci taps 16,14,13,11 shifted in at the LSB.
    assign lfsr_d = {lfsr_q[14:0],
                     lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign sel    = {1'b0, lfsr_q[3:0]} % 5'(BTN_W);
    assign wdata  = BTN_W'(1) << sel;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) lfsr_q <= 16'hACE1;
        else          lfsr_q <= lfsr_d;
    end
`else
    assign wdata = jogada_q;
`endif

    always_comb begin
        endereco_d = endereco_q;
        if (zeraE)       endereco_d = '0;
        else if (contaE) endereco_d = endereco_q + ADDR_W'(1);

        limite_d = limite_q;
        if (zeraL)       limite_d = '0;
        else if (contaL) limite_d = limite_q + ADDR_W'(1);

        tmr_d = tmr_q;
        if (zeraTMR)       tmr_d = '0;
        else if (contaTMR) tmr_d = (tmr_q == TMR_LAST) ? '0 : tmr_q + TMR_W'(1);

        // Any activity restarts the idle count; otherwise it saturates.
        tout_d = tout_q;
        if (contaE || zeraE || tem) tout_d = '0;
        else if (!tout_hit)         tout_d = tout_q + TO_W'(1);

        jogada_d = jogada_q;
        if (zeraR)          jogada_d = '0;
        else if (registraR) jogada_d = botoes;

        memoria_d = memoria_q;
        if (zeraM)          memoria_d = '0;
        else if (registraM) memoria_d = rd_q;

        hist_d = zeraL ? 1'b0 : tem;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            endereco_q <= '0;
            limite_q   <= '0;
            tmr_q      <= '0;
            tout_q     <= '0;
            jogada_q   <= '0;
            memoria_q  <= '0;
            hist_q     <= 1'b0;
        end else begin
            endereco_q <= endereco_d;
            limite_q   <= limite_d;
            tmr_q      <= tmr_d;
            tout_q     <= tout_d;
            jogada_q   <= jogada_d;
            memoria_q  <= memoria_d;
            hist_q     <= hist_d;
        end
    end

    // Sequence RAM: read-before-write, no reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (escreveM) ram[endereco_q] <= wdata;
        rd_q <= ram[endereco_q];
    end

    // Combinational flags are forced low while reset is held.
    assign fimE          = reset_n & (endereco_q == '1);
    assign fimL          = reset_n & (limite_q == '1);
    assign fimTMR        = reset_n & (tmr_q == TMR_LAST);
    assign jogada_feita  = reset_n & tem & ~hist_q;
    assign jogada_valida = reset_n & (jogada_q != '0)
                         & ((jogada_q & (jogada_q - BTN_W'(1))) == '0);
    assign chavesIgualMemoria         = reset_n & (jogada_q == memoria_q);
    assign enderecoIgualLimite        = reset_n & (endereco_q == limite_q);
    assign enderecoMenorOuIgualLimite = reset_n & (endereco_q <= limite_q);
    assign timeout       = reset_n & tout_hit;
    assign db_tem_jogada = reset_n & tem;
    assign db_contagem   = endereco_q;
    assign db_limite     = limite_q;
    assign db_jogada     = jogada_q;
    assign db_memoria    = memoria_q;

endmodule

// File: tb/tb_fluxo_dados_genius_param.sv
// Self-checking bench for fluxo_dados_genius_param.
// Table vectors, directed corner sequences and a random phase vs a model.
module tb_fluxo_dados_genius_param;

    localparam int BTN_W = 4;
    localparam int ADDR_W = 4;
    localparam int DEPTH = 16;
    localparam int TOUT = 5000;
    localparam int SHOW = 500;

    logic clock = 1'b0;
    logic reset_n;
    logic [3:0] botoes;
    logic zeraE, zeraL, zeraR, zeraM, zeraTMR;
    logic contaE, contaL, contaTMR, registraR, registraM, escreveM;
    logic fimE, fimL, fimTMR, jogada_feita, jogada_valida;
    logic chavesIgualMemoria, enderecoIgualLimite, enderecoMenorOuIgualLimite;
    logic timeout, db_tem_jogada;
    logic [3:0] db_contagem, db_limite, db_jogada, db_memoria;

    fluxo_dados_genius_param #(
        .BTN_W(BTN_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TOUT), .SHOW_CYC(SHOW)
    ) u_dut (
        .clock(clock), .reset_n(reset_n), .botoes(botoes),
        .zeraE(zeraE), .zeraL(zeraL), .zeraR(zeraR), .zeraM(zeraM),
        .zeraTMR(zeraTMR), .contaE(contaE), .contaL(contaL),
        .contaTMR(contaTMR), .registraR(registraR), .registraM(registraM),
        .escreveM(escreveM), .fimE(fimE), .fimL(fimL), .fimTMR(fimTMR),
        .jogada_feita(jogada_feita), .jogada_valida(jogada_valida),
        .chavesIgualMemoria(chavesIgualMemoria),
        .enderecoIgualLimite(enderecoIgualLimite),
        .enderecoMenorOuIgualLimite(enderecoMenorOuIgualLimite),
        .timeout(timeout), .db_tem_jogada(db_tem_jogada),
        .db_contagem(db_contagem), .db_limite(db_limite),
        .db_jogada(db_jogada), .db_memoria(db_memoria)
    );

`ifdef GERA_ALEATORIO_EN
    logic x_fimE, x_fimL, x_fimTMR, x_feita, x_valida, x_chaves, x_eq, x_le;
    logic x_tout, x_tem;
    logic [3:0] x_cont, x_lim;
    logic [2:0] x_jog, x_mem;

    fluxo_dados_genius_param #(
        .BTN_W(3), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TOUT), .SHOW_CYC(SHOW)
    ) u_dut3 (
        .clock(clock), .reset_n(reset_n), .botoes(botoes[2:0]),
        .zeraE(zeraE), .zeraL(zeraL), .zeraR(zeraR), .zeraM(zeraM),
        .zeraTMR(zeraTMR), .contaE(contaE), .contaL(contaL),
        .contaTMR(contaTMR), .registraR(registraR), .registraM(registraM),
        .escreveM(escreveM), .fimE(x_fimE), .fimL(x_fimL), .fimTMR(x_fimTMR),
        .jogada_feita(x_feita), .jogada_valida(x_valida),
        .chavesIgualMemoria(x_chaves), .enderecoIgualLimite(x_eq),
        .enderecoMenorOuIgualLimite(x_le), .timeout(x_tout),
        .db_tem_jogada(x_tem), .db_contagem(x_cont), .db_limite(x_lim),
        .db_jogada(x_jog), .db_memoria(x_mem)
    );
`endif

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Behavioural model state.
    int m_addr, m_lim, m_tmr, m_idle;
    logic [3:0] m_jog, m_mem, m_rd;
    bit m_rd_ok, m_mem_ok, m_hist;
    logic [3:0] m_ram [DEPTH];
    bit m_ram_ok [DEPTH];
    logic [15:0] m_lfsr;

    typedef struct {
        logic [3:0] btn;
        bit         valid;
    } mv_vec_t;

    typedef struct {
        int addr;
        bit le;
        bit eq;
        bit fim;
    } cmp_vec_t;

    mv_vec_t  mv_tab [6];
    cmp_vec_t cmp_tab [16];

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    task automatic chkv(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] mdl_wd();
`ifdef GERA_ALEATORIO_EN
        return 4'(1 << (int'(m_lfsr[3:0]) % BTN_W));
`else
        return m_jog;
`endif
    endfunction

    task automatic model_reset();
        m_addr = 0; m_lim = 0; m_tmr = 0; m_idle = 0;
        m_jog = '0; m_mem = '0; m_mem_ok = 1'b1; m_hist = 1'b0;
        m_lfsr = 16'hACE1;
    endtask

    task automatic model_step();
        logic [3:0] old_rd;
        bit old_ok;
        logic [3:0] wd;
        bit press;
        old_rd = m_rd;
        old_ok = m_rd_ok;
        m_rd = m_ram[m_addr];
        m_rd_ok = m_ram_ok[m_addr];
        if (!reset_n) return;
        press = (botoes != 0);
        wd = mdl_wd();
        if (escreveM) begin
            m_ram[m_addr] = wd;
            m_ram_ok[m_addr] = 1'b1;
        end
        if (zeraM) begin
            m_mem = '0; m_mem_ok = 1'b1;
        end else if (registraM) begin
            m_mem = old_rd; m_mem_ok = old_ok;
        end
        if (zeraR) m_jog = '0;
        else if (registraR) m_jog = botoes;
        m_hist = zeraL ? 1'b0 : press;
        if (contaE || zeraE || press) m_idle = 0;
        else if (m_idle < TOUT) m_idle++;
        if (zeraE) m_addr = 0;
        else if (contaE) m_addr = (m_addr + 1) % DEPTH;
        if (zeraL) m_lim = 0;
        else if (contaL) m_lim = (m_lim + 1) % DEPTH;
        if (zeraTMR) m_tmr = 0;
        else if (contaTMR) m_tmr = (m_tmr + 1) % SHOW;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    task automatic check_all();
        bit r;
        bit press;
        r = reset_n;
        press = (botoes != 0);
        chk1("fimE", fimE, r && m_addr == DEPTH - 1);
        chk1("fimL", fimL, r && m_lim == DEPTH - 1);
        chk1("fimTMR", fimTMR, r && m_tmr == SHOW - 1);
        chk1("jogada_feita", jogada_feita, r && press && !m_hist);
        chk1("jogada_valida", jogada_valida, r && $countones(m_jog) == 1);
        chk1("end_eq_lim", enderecoIgualLimite, r && m_addr == m_lim);
        chk1("end_le_lim", enderecoMenorOuIgualLimite, r && m_addr <= m_lim);
        chk1("timeout", timeout, r && m_idle >= TOUT);
        chk1("db_tem_jogada", db_tem_jogada, r && press);
        chkv("db_contagem", int'(db_contagem), m_addr);
        chkv("db_limite", int'(db_limite), m_lim);
        chkv("db_jogada", int'(db_jogada), int'(m_jog));
        if (m_mem_ok) begin
            chk1("chaves", chavesIgualMemoria, r && m_jog == m_mem);
            chkv("db_memoria", int'(db_memoria), int'(m_mem));
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            #1;
            check_all();
            cyc();
        end
    endtask

    task automatic idle_in();
        botoes = '0;
        zeraE = 0; zeraL = 0; zeraR = 0; zeraM = 0; zeraTMR = 0;
        contaE = 0; contaL = 0; contaTMR = 0;
        registraR = 0; registraM = 0; escreveM = 0;
    endtask

    initial begin
        int pulses;
        logic [3:0] exp_w;
        mv_tab[0] = '{4'b0110, 1'b0};
        mv_tab[1] = '{4'b1000, 1'b1};
        mv_tab[2] = '{4'b0000, 1'b0};
        mv_tab[3] = '{4'b0001, 1'b1};
        mv_tab[4] = '{4'b1111, 1'b0};
        mv_tab[5] = '{4'b0011, 1'b0};
        for (int i = 0; i < 16; i++)
            cmp_tab[i] = '{i, (i <= 5), (i == 5), (i == 15)};
        for (int i = 0; i < DEPTH; i++) m_ram_ok[i] = 1'b0;
        m_rd_ok = 1'b0;
        m_rd = '0;

        idle_in();
        reset_n = 1'b0;
        model_reset();
        run(2);
        reset_n = 1'b1;

        // Count up a while, then drop reset asynchronously.
        contaE = 1; contaL = 1; contaTMR = 1; registraR = 1;
        botoes = 4'b0100;
        run(7);
        idle_in();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chkv("rst_addr", int'(db_contagem), 0);
        chkv("rst_lim", int'(db_limite), 0);
        chkv("rst_jog", int'(db_jogada), 0);
        chk1("rst_eq", enderecoIgualLimite, 1'b0);
        chk1("rst_chaves", chavesIgualMemoria, 1'b0);
        check_all();
        cyc();
        run(2);
        reset_n = 1'b1;

        // Idle timeout from release.
        run(TOUT - 1);
        chk1("tout_pre", timeout, 1'b0);
        run(1);
        chk1("tout_rise", timeout, 1'b1);
        run(20);
        chk1("tout_hold", timeout, 1'b1);
        contaE = 1;
        run(1);
        contaE = 0;
        chk1("tout_clr", timeout, 1'b0);
        run(3000);
        botoes = 4'b0001;
        run(1);
        botoes = '0;
        run(TOUT - 1);
        chk1("tout_restart_pre", timeout, 1'b0);
        run(1);
        chk1("tout_restart_rise", timeout, 1'b1);

        // Write then read back at address 3.
        botoes = 4'b0100; registraR = 1;
        run(1);
        idle_in();
        zeraE = 1; run(1); zeraE = 0;
        contaE = 1; run(3); contaE = 0;
        exp_w = mdl_wd();
`ifndef GERA_ALEATORIO_EN
        exp_w = 4'b0100;
`endif
        escreveM = 1; run(1); escreveM = 0;
        zeraE = 1; run(1); zeraE = 0;
        contaE = 1; run(3); contaE = 0;
        run(1);
        registraM = 1; run(1); registraM = 0;
        chkv("wr_rd_mem", int'(db_memoria), int'(exp_w));
`ifndef GERA_ALEATORIO_EN
        chk1("wr_rd_eq", chavesIgualMemoria, 1'b1);
`endif

        // Move validation table.
        foreach (mv_tab[i]) begin
            botoes = mv_tab[i].btn; registraR = 1;
            run(1);
            botoes = '0; registraR = 0;
            chk1($sformatf("valid_%0d", i), jogada_valida, mv_tab[i].valid);
            run(1);
        end

        // Held press: a single pulse.
        pulses = 0;
        botoes = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_all();
            pulses += int'(jogada_feita);
            cyc();
        end
        botoes = '0;
        chkv("hold_pulses", pulses, 1);
        run(1);

        // Limit = 5, sweep the address counter.
        zeraL = 1; zeraE = 1; run(1); zeraL = 0; zeraE = 0;
        contaL = 1; run(5); contaL = 0;
        foreach (cmp_tab[i]) begin
            chkv($sformatf("cmp_addr_%0d", i), int'(db_contagem), cmp_tab[i].addr);
            chk1($sformatf("cmp_le_%0d", i), enderecoMenorOuIgualLimite, cmp_tab[i].le);
            chk1($sformatf("cmp_eq_%0d", i), enderecoIgualLimite, cmp_tab[i].eq);
            chk1($sformatf("cmp_fimE_%0d", i), fimE, cmp_tab[i].fim);
            contaE = 1; run(1); contaE = 0;
        end
        chkv("addr_wrap", int'(db_contagem), 0);

        // Display timer: every 500th clock.
        zeraTMR = 1; run(1); zeraTMR = 0;
        contaTMR = 1;
        pulses = 0;
        for (int k = 0; k < 3 * SHOW; k++) begin
            #1;
            check_all();
            if (fimTMR) begin
                pulses++;
                chkv("tmr_pos", k % SHOW, SHOW - 1);
            end
            cyc();
        end
        contaTMR = 0;
        chkv("tmr_pulses", pulses, 3);

        // Fill RAM so every word is known to the model.
        zeraE = 1; run(1); zeraE = 0;
        for (int i = 0; i < DEPTH; i++) begin
            botoes = 4'($urandom); registraR = 1; run(1); registraR = 0;
            botoes = '0; escreveM = 1; contaE = 1; run(1);
            escreveM = 0; contaE = 0;
        end
        run(2);

        // Random phase against the model.
        for (int n = 0; n < 3000; n++) begin
            int b;
            b = int'($urandom_range(0, 9));
            if (b < 5) botoes = '0;
            else if (b < 8) botoes = 4'(1 << $urandom_range(0, 3));
            else botoes = 4'($urandom);
            zeraE = ($urandom_range(0, 15) == 0);
            zeraL = ($urandom_range(0, 31) == 0);
            zeraR = ($urandom_range(0, 15) == 0);
            zeraM = ($urandom_range(0, 15) == 0);
            zeraTMR = ($urandom_range(0, 31) == 0);
            contaE = ($urandom_range(0, 2) == 0);
            contaL = ($urandom_range(0, 4) == 0);
            contaTMR = ($urandom_range(0, 1) == 0);
            registraR = ($urandom_range(0, 3) == 0);
            registraM = ($urandom_range(0, 3) == 0);
            escreveM = ($urandom_range(0, 3) == 0);
            run(1);
        end
        idle_in();
        run(2);

`ifdef GERA_ALEATORIO_EN
        begin
            logic [3:0] e4;
            logic [2:0] e3;
            reset_n = 1'b0;
            model_reset();
            run(2);
            reset_n = 1'b1;
            e4 = 4'(1 << (int'(m_lfsr[3:0]) % 4));
            e3 = 3'(1 << (int'(m_lfsr[3:0]) % 3));
            escreveM = 1; run(1); escreveM = 0;
            run(1);
            registraM = 1; run(1); registraM = 0;
            chkv("lfsr_w4", int'(db_memoria), int'(e4));
            chkv("lfsr_w3", int'(x_mem), int'(e3));
            chkv("lfsr_onehot3", $countones(x_mem), 1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
